// File: rtl/pmod_debounce.sv
// pmod_debounce: synchronize, debounce and edge-detect PMOD switch lines with sticky flags and a press counter
module pmod_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pmod_b,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] sticky,
    output logic [7:0]       rise_count
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1, s2, hit;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [7:0]       pop;

    // two-flop synchronizer; only s2 feeds the debounce logic
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pmod_b;
            s2 <= s1;
        end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign hit[i] = s2[i] != level[i] && cnt[i] == LAST;
        // stability counter: runs while the line disagrees with level, restarts on agreement or acceptance
        always_ff @(posedge clk or posedge rst)
            if (rst) cnt[i] <= '0;
            else     cnt[i] <= (s2[i] == level[i] || hit[i]) ? '0 : cnt[i] + 1'b1;
    end

    // accept the new value and emit a single-cycle edge pulse in the same cycle level changes
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
        end else begin
            level <= level ^ hit;
            rise  <= hit & s2;
            fall  <= hit & ~s2;
        end

    // number of bits rising this cycle
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + 8'(rise[i]);
    end

    // sticky press flags (set beats clear) and wrapping press counter
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sticky     <= '0;
            rise_count <= '0;
        end else begin
            sticky     <= rise | (sticky & ~clr);
            rise_count <= rise_count + pop;
        end
endmodule

// File: tb/tb_pmod_debounce.sv
// tb_pmod_debounce: randomized and directed stimulus against a window-based reference model with a scoreboard
module tb_pmod_debounce;
    localparam int W = 8;
    localparam int D = 4;

    typedef struct packed {
        logic [7:0] lvl;
        logic [7:0] ri;
        logic [7:0] fa;
        logic [7:0] st;
        logic [7:0] rc;
    } exp_t;

    logic         clk = 0;
    logic         rst = 1;
    logic [W-1:0] pmod_b = '0;
    logic [W-1:0] clr = '0;
    logic [W-1:0] level, rise, fall, sticky;
    logic [7:0]   rise_count;

    int total = 0;
    int bad = 0;
    bit done = 0;

    exp_t sb[$];

    pmod_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .pmod_b(pmod_b), .clr(clr),
        .level(level), .rise(rise), .fall(fall), .sticky(sticky),
        .rise_count(rise_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    // Reference model: a line is accepted once the synchronized value (pin two edges back)
    // has disagreed with the current level over a full window of D edges since the last change.
    logic [7:0] pins[$];
    logic [7:0] s2h[$];
    int         n = 0;
    int         last[W];
    logic [7:0] m_lvl = 0, m_rise = 0, m_fall = 0, m_st = 0, m_rc = 0;

    always @(posedge clk) begin
        logic [7:0] nr, nf, s2v;
        bit ok;
        if (rst) begin
            n = 0;
            pins.delete();
            s2h.delete();
            for (int i = 0; i < W; i++) last[i] = 0;
            m_lvl = 0; m_rise = 0; m_fall = 0; m_st = 0; m_rc = 0;
        end else begin
            n++;
            pins.push_back(pmod_b);
            s2v = (n >= 3) ? pins[n-3] : 8'h00;
            s2h.push_back(s2v);
            nr = 0;
            nf = 0;
            for (int i = 0; i < W; i++) begin
                if (n - last[i] >= D) begin
                    ok = 1;
                    for (int j = 0; j < D; j++)
                        if (s2h[n-1-j][i] == m_lvl[i]) ok = 0;
                    if (ok) begin
                        if (m_lvl[i]) nf[i] = 1; else nr[i] = 1;
                        last[i] = n;
                    end
                end
            end
            m_st = m_rise | (m_st & ~clr);
            m_rc = m_rc + 8'($countones(m_rise));
            m_lvl = m_lvl ^ nr ^ nf;
            m_rise = nr;
            m_fall = nf;
        end
        sb.push_back('{m_lvl, m_rise, m_fall, m_st, m_rc});
    end

    // monitor: every cycle the DUT presents its outputs; pop the expected entry and compare
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("level", level, e.lvl);
                chk("rise", rise, e.ri);
                chk("fall", fall, e.fa);
                chk("sticky", sticky, e.st);
                chk("rise_count", rise_count, e.rc);
            end
        end
    end

    task automatic hold(input logic [7:0] p, input logic [7:0] c, input int cyc);
        pmod_b = p;
        clr = c;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic do_reset(input int cyc);
        rst = 1;
        repeat (cyc) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        @(negedge clk);
        pmod_b = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset_level", level, 0);
        chk("reset_count", rise_count, 0);
        rst = 0;
        hold(8'hFF, 0, 12);
        hold(8'h00, 0, 12);
        hold(8'h01, 0, 3);
        hold(8'h00, 0, 10);
        hold(8'h01, 0, 10);
        hold(8'h00, 0, 10);
        hold(8'h00, 8'h01, 1);
        hold(8'h00, 0, 4);
        hold(8'h02, 0, 6);
        hold(8'h02, 8'h02, 1);
        hold(8'h02, 0, 6);
        do_reset(2);
        for (int k = 0; k < 260; k++) begin
            hold(8'h04, 0, 6);
            hold(8'h00, 0, 6);
        end
        hold(8'h00, 0, 6);
        chk("wrap_count", rise_count, 4);
        hold(8'hF8, 0, 10);
        chk("multi_rise_count", rise_count, 9);
        hold(8'h00, 0, 10);
        hold(8'h10, 0, 3);
        do_reset(2);
        hold(8'h10, 0, 10);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3));
            hold(8'($urandom), 8'($urandom), $urandom_range(1, 8));
        end
        hold(8'h00, 0, 10);
        done = 1;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
